// File: rtl/seven_segment_scan_ctrl.sv
// Scans DIGITS hex nibbles onto a shared 7-segment bus with one-hot digit enables,
// an anti-ghosting blank at the start of each slot, and frame-aligned value updates.
//   state | meaning
//   IDLE  | display dark, counters held at 0, pending copies straight to display
//   BLANK | slot_cnt 0..BLANK_CYCLES-1, all digit enables low
//   SHOW  | slot_cnt BLANK_CYCLES..SCAN_DIV-1, current digit lit
module seven_segment_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           slot_cnt, cnt_nxt;
  logic [IW-1:0]           digit_idx, idx_nxt;
  logic [DIGITS-1:0][3:0]  display, pending, display_nxt;
  logic                    copy;
  logic [6:0]              segments_nxt;
  logic [DIGITS-1:0]       digit_en_nxt;
  logic                    frame_start_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    case (h)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  // pending_full is the complement of load_ready, so only one flop tracks it.
  // Copies happen during the frame_start cycle (or any IDLE cycle).
  assign copy        = !load_ready && (state == IDLE || frame_start);
  assign display_nxt = copy ? pending : display;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = slot_cnt;
    idx_nxt   = digit_idx;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        BLANK: begin
          cnt_nxt = slot_cnt + 1'b1;
          if (slot_cnt == CW'(BLANK_CYCLES - 1)) state_nxt = SHOW;
        end
        SHOW: begin
          if (slot_cnt == CW'(SCAN_DIV - 1)) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
          end else begin
            cnt_nxt = slot_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with state.
  always_comb begin
    segments_nxt    = '0;
    digit_en_nxt    = '0;
    frame_start_nxt = (state_nxt == BLANK) && (cnt_nxt == '0) && (idx_nxt == '0);
    if (state_nxt == SHOW) begin
      digit_en_nxt = DIGITS'(1) << idx_nxt;
      segments_nxt = seg_decode(display_nxt[idx_nxt]);
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      slot_cnt    <= '0;
      digit_idx   <= '0;
      display     <= '0;
      pending     <= '0;
      load_ready  <= 1'b1;
      segments    <= '0;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot_cnt    <= cnt_nxt;
      digit_idx   <= idx_nxt;
      segments    <= segments_nxt;
      digit_en    <= digit_en_nxt;
      frame_start <= frame_start_nxt;
      display     <= display_nxt;
      if (copy) begin
        load_ready <= 1'b1;
      end else if (load_valid && load_ready) begin
        pending    <= load_value;
        load_ready <= 1'b0;
      end
    end
  end

endmodule
